palette_fade_ctrl: RTL and testbench

//  Sequences the palette lookup stage for screen fades between game screens.
//  - Forwards each pixel's palette index to color_table.
//  - Scales the returned R/G/B by a fade level that steps once per N frames.
//  - Registers the result for the VGA output.
//  - Sits between the sprite/background compositor and the VGA DAC pins.

---
 rtl/palette_fade_if.sv | 23 ++
 rtl/palette_fade_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_palette_fade_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/palette_fade_if.sv
// Pixel bus around the palette lookup: compositor index in, color_table RGB in,
// remapped index out to color_table and scaled RGB out to the VGA DAC.
interface palette_fade_if;
    logic [3:0] pixel_color;
    logic [3:0] color_idx;
    logic [7:0] R_in;
    logic [7:0] G_in;
    logic [7:0] B_in;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    // master: compositor/color_table side; slave: the fade controller
    modport master (
        output pixel_color, R_in, G_in, B_in,
        input  color_idx, VGA_R, VGA_G, VGA_B
    );

    modport slave (
        input  pixel_color, R_in, G_in, B_in,
        output color_idx, VGA_R, VGA_G, VGA_B
    );
endinterface

// File: rtl/palette_fade_ctrl.sv
// Palette lookup stage with frame-stepped fade to/from black and registered RGB out.
// Define PFC_FLASH_EN to add flash_req, which remaps index 0 to 8 for FLASH_FRAMES frames.
module palette_fade_ctrl #(
    parameter int LEVEL_BITS      = 4,
    parameter int FRAMES_PER_STEP = 2,
    parameter int FLASH_FRAMES    = 8
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_start,
    input  logic                  fade_out,
    input  logic                  fade_in,
`ifdef PFC_FLASH_EN
    input  logic                  flash_req,
`endif
    palette_fade_if.slave         pix,
    output logic [LEVEL_BITS:0]   level,
    output logic                  busy,
    output logic                  done
);

    localparam int LW     = LEVEL_BITS + 1;
    localparam int PROD_W = 8 + LW;
    localparam logic [LW-1:0] LEVEL_MAX = LW'(2 ** LEVEL_BITS);
    localparam int CNT_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_FRAMES);
    localparam logic [3:0] FLASH_IDX = 4'd8;

    typedef enum logic [1:0] {
        VISIBLE    = 2'd0,
        FADING_OUT = 2'd1,
        BLACK      = 2'd2,
        FADING_IN  = 2'd3
    } state_e;

    state_e             state_q;
    logic [LW-1:0]      level_q;
    logic [LW-1:0]      level_up;
    logic [LW-1:0]      level_dn;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               take_in;

    // fade_out has priority whenever both commands arrive together
    assign take_in  = fade_in && !fade_out;
    assign level_up = (level_q >= LEVEL_MAX) ? LEVEL_MAX : level_q + 1'b1;
    assign level_dn = (level_q == '0) ? '0 : level_q - 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= VISIBLE;
            level_q <= LEVEL_MAX;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                VISIBLE: begin
                    if (fade_out) begin
                        state_q <= FADING_OUT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                BLACK: begin
                    if (take_in) begin
                        state_q <= FADING_IN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FADING_OUT: begin
                    if (take_in) begin
                        state_q <= FADING_IN;
                        cnt_q   <= '0;
                    end else if (frame_start) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            level_q <= level_dn;
                            if (level_dn == '0) begin
                                state_q <= BLACK;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                FADING_IN: begin
                    if (fade_out) begin
                        state_q <= FADING_OUT;
                        cnt_q   <= '0;
                    end else if (frame_start) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            level_q <= level_up;
                            if (level_up == LEVEL_MAX) begin
                                state_q <= VISIBLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= VISIBLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign level = level_q;
    assign busy  = busy_q;
    assign done  = done_q;

    // Flash countdown: remaining frame_start pulses of the current flash
    logic [FLASH_W-1:0] flash_cnt_q;
    logic [FLASH_W-1:0] flash_cnt_d;
    logic               flash_start;
    logic               flash_active;

`ifdef PFC_FLASH_EN
    assign flash_start = flash_req;
`else
    assign flash_start = 1'b0;
`endif

    assign flash_active = (flash_cnt_q != '0);

    always_comb begin
        flash_cnt_d = flash_cnt_q;
        if (flash_start) begin
            flash_cnt_d = FLASH_LOAD;
        end else if (frame_start && flash_active) begin
            flash_cnt_d = flash_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            flash_cnt_q <= '0;
        end else begin
            flash_cnt_q <= flash_cnt_d;
        end
    end

    always_comb begin
        // NOTE: a default assignment first guarantees every path drives
        // color_idx, so no latch is inferred.
        pix.color_idx = pix.pixel_color;
        if (flash_active && (pix.pixel_color == 4'd0)) begin
            pix.color_idx = FLASH_IDX;
        end
    end

    // (x * level) >> LEVEL_BITS, clamped to 8 bits; full level is an exact pass-through
    function automatic logic [7:0] scale(input logic [7:0] x, input logic [LW-1:0] lvl);
        logic [PROD_W-1:0] prod;
        prod = (PROD_W'(x) * PROD_W'(lvl)) >> LEVEL_BITS;
        return (prod > PROD_W'(8'hFF)) ? 8'hFF : prod[7:0];
    endfunction

    logic [7:0] vga_r_d, vga_g_d, vga_b_d;
    logic [7:0] vga_r_q, vga_g_q, vga_b_q;

    always_comb begin
        vga_r_d = scale(pix.R_in, level_q);
        vga_g_d = scale(pix.G_in, level_q);
        vga_b_d = scale(pix.B_in, level_q);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            vga_r_q <= '0;
            vga_g_q <= '0;
            vga_b_q <= '0;
        end else begin
            vga_r_q <= vga_r_d;
            vga_g_q <= vga_g_d;
            vga_b_q <= vga_b_d;
        end
    end

    assign pix.VGA_R = vga_r_q;
    assign pix.VGA_G = vga_g_q;
    assign pix.VGA_B = vga_b_q;

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Self-checking bench for palette_fade_ctrl: directed fade scenarios, then random
// traffic against a level/direction reference model. Flash checks need PFC_FLASH_EN.
module tb_palette_fade_ctrl;

    localparam int FPS   = 2;
    localparam int FLASH = 8;
    localparam int LMAX  = 16;
`ifdef PFC_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       fade_out = 1'b0;
    logic       fade_in = 1'b0;
`ifdef PFC_FLASH_EN
    logic       flash_req = 1'b0;
`endif
    logic [4:0] level;
    logic       busy;
    logic       done;

    palette_fade_if pix ();

    palette_fade_ctrl #(
        .LEVEL_BITS      (4),
        .FRAMES_PER_STEP (FPS),
        .FLASH_FRAMES    (FLASH)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .fade_out    (fade_out),
        .fade_in     (fade_in),
`ifdef PFC_FLASH_EN
        .flash_req   (flash_req),
`endif
        .pix         (pix),
        .level       (level),
        .busy        (busy),
        .done        (done)
    );

    always #10 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    // Reference model: level as an integer, direction -1/0/+1, frames seen since last step
    int m_level = LMAX;
    int m_dir = 0;
    int m_frames = 0;
    int m_flash = 0;
    int m_vr = 0, m_vg = 0, m_vb = 0;
    bit m_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int scale_ref(input int x, input int l);
        int p;
        p = (x * l) / 16;
        return (p > 255) ? 255 : p;
    endfunction

    function automatic int clamp_level(input int l);
        if (l < 0) return 0;
        if (l > LMAX) return LMAX;
        return l;
    endfunction

    task automatic cycle(input bit fs, input bit fo, input bit fi, input bit fl,
                         input int pc, input int r, input int g, input int b);
        bit out_ok, in_ok, fl_eff;
        fl_eff = fl && FLASH_ON;
        frame_start = fs;
        fade_out = fo;
        fade_in = fi;
`ifdef PFC_FLASH_EN
        flash_req = fl;
`endif
        pix.pixel_color = 4'(pc);
        pix.R_in = 8'(r);
        pix.G_in = 8'(g);
        pix.B_in = 8'(b);
        #1;
        check("color_idx", 32'(pix.color_idx), (m_flash > 0 && pc == 0) ? 8 : pc);

        m_vr = scale_ref(r, m_level);
        m_vg = scale_ref(g, m_level);
        m_vb = scale_ref(b, m_level);
        m_done = 1'b0;
        if (fl_eff) m_flash = FLASH;
        else if (fs && m_flash > 0) m_flash--;

        out_ok = fo && (m_dir == 1 || (m_dir == 0 && m_level == LMAX));
        in_ok  = fi && !fo && (m_dir == -1 || (m_dir == 0 && m_level == 0));
        if (out_ok) begin
            m_dir = -1;
            m_frames = 0;
        end else if (in_ok) begin
            m_dir = 1;
            m_frames = 0;
        end else if (fs && m_dir != 0) begin
            m_frames++;
            if (m_frames == FPS) begin
                m_frames = 0;
                m_level = clamp_level(m_level + m_dir);
                if (m_level == 0 || m_level == LMAX) begin
                    m_done = 1'b1;
                    m_dir = 0;
                end
            end
        end

        @(posedge Clk);
        #1;
        check("level", 32'(level), m_level);
        check("busy", 32'(busy), (m_dir != 0) ? 1 : 0);
        check("done", 32'(done), 32'(m_done));
        check("vga_r", 32'(pix.VGA_R), m_vr);
        check("vga_g", 32'(pix.VGA_G), m_vg);
        check("vga_b", 32'(pix.VGA_B), m_vb);
        if (done === 1'b1) done_count++;
        frame_start = 1'b0;
        fade_out = 1'b0;
        fade_in = 1'b0;
`ifdef PFC_FLASH_EN
        flash_req = 1'b0;
`endif
    endtask

    task automatic frames(input int n, input int pc);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, pc, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            cycle(1'b0, 1'b0, 1'b0, 1'b0, pc, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        end
    endtask

    task automatic do_reset(input int n);
        Reset_n = 1'b0;
        frame_start = 1'b0;
        fade_out = 1'b0;
        fade_in = 1'b0;
`ifdef PFC_FLASH_EN
        flash_req = 1'b0;
`endif
        repeat (n) @(posedge Clk);
        #1;
        m_level = LMAX;
        m_dir = 0;
        m_frames = 0;
        m_flash = 0;
        check("rst_level", 32'(level), LMAX);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_vga_r", 32'(pix.VGA_R), 0);
        check("rst_vga_g", 32'(pix.VGA_G), 0);
        check("rst_vga_b", 32'(pix.VGA_B), 0);
        Reset_n = 1'b1;
    endtask

    initial begin
        pix.pixel_color = 4'd0;
        pix.R_in = 8'd0;
        pix.G_in = 8'd0;
        pix.B_in = 8'd0;

        // Reset, then full-brightness pass-through with one cycle latency
        do_reset(2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2, 'hFF, 'hAE, 'hC9);
        check("t1_vga_r", 32'(pix.VGA_R), 32'hFF);
        check("t1_vga_g", 32'(pix.VGA_G), 32'hAE);
        check("t1_vga_b", 32'(pix.VGA_B), 32'hC9);

        // fade_in while VISIBLE is ignored
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 2, 'hFF, 'hAE, 'hC9);
        check("t_ignore_in_busy", 32'(busy), 0);

        // Fade out over 32 frames, checking scaling at levels 8 and 1
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 2, 'hFF, 'hAE, 'hC9);
        check("t2_busy", 32'(busy), 1);
        done_count = 0;
        for (int f = 1; f <= 32; f++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 2, 'hFF, 'hAE, 'hC9);
            if (f == 2) check("t2_first_step", 32'(level), 15);
            if (f == 16) begin
                cycle(1'b0, 1'b0, 1'b0, 1'b0, 2, 'h88, 'h00, 'h00);
                check("t3_lvl8_r", 32'(pix.VGA_R), 32'h44);
            end else if (f == 30) begin
                cycle(1'b0, 1'b0, 1'b0, 1'b0, 2, 'hFF, 'h00, 'h00);
                check("t3_lvl1_r", 32'(pix.VGA_R), 32'h0F);
            end else begin
                cycle(1'b0, 1'b0, 1'b0, 1'b0, 2, 'hFF, 'hAE, 'hC9);
            end
        end
        check("t2_level0", 32'(level), 0);
        check("t2_done_once", 32'(done_count), 1);
        check("t2_black_busy", 32'(busy), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2, 'hFF, 'hAE, 'hC9);
        check("t2_black_vga", 32'(pix.VGA_R), 0);

        // Fade back in, then fade out to 10 and reverse
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1, 'h10, 'h20, 'h30);
        frames(32, 1);
        check("t4_visible", 32'(level), LMAX);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1, 'h10, 'h20, 'h30);
        frames(12, 1);
        check("t4_level10", 32'(level), 10);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1, 'h10, 'h20, 'h30);
        check("t4_rev_busy", 32'(busy), 1);
        done_count = 0;
        frames(12, 1);
        check("t4_level16", 32'(level), LMAX);
        check("t4_done_once", 32'(done_count), 1);
        check("t4_idle", 32'(busy), 0);

        // Simultaneous commands: fade_out wins, from VISIBLE and from FADING_IN
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1, 'h10, 'h20, 'h30);
        check("t4_both_busy", 32'(busy), 1);
        frames(2, 1);
        check("t4_both_lvl15", 32'(level), 15);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1, 'h10, 'h20, 'h30);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1, 'h10, 'h20, 'h30);
        frames(2, 1);
        check("t4_both_lvl14", 32'(level), 14);

        // Reset mid-fade at level 5
        frames(18, 1);
        check("t5_level5", 32'(level), 5);
        do_reset(1);

        // Command with frame_start in the same cycle: that frame does not step
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 3, 'h80, 'h80, 'h80);
        frames(1, 3);
        check("t_cmd_frame_no_step", 32'(level), LMAX);
        frames(1, 3);
        check("t_cmd_frame_step", 32'(level), 15);

`ifdef PFC_FLASH_EN
        // Flash remaps index 0 for exactly FLASH frames
        do_reset(1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 2, 3);
        for (int f = 0; f < FLASH; f++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 2, 3);
            check("t6_flash_on", 32'(pix.color_idx), 8);
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 3, 1, 2, 3);
            check("t6_flash_other", 32'(pix.color_idx), 3);
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 2, 3);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 2, 3);
        check("t6_flash_off", 32'(pix.color_idx), 0);
`endif

        // Random traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            int sel;
            bit fs, fo, fi, fl;
            sel = $urandom_range(0, 59);
            fs = ($urandom_range(0, 2) == 0);
            fo = (sel == 0);
            fi = (sel == 1);
            fl = (sel == 2);
            if ($urandom_range(0, 999) == 0) begin
                do_reset(1);
            end else begin
                cycle(fs, fo, fi, fl, $urandom_range(0, 8),
                      $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
